// File: rtl/linear_layer_start_fifo.sv
// linear_layer_start_fifo: start-token SRL FIFO with fall-through head and registered full/empty flags.
// Define START_FIFO_LEVEL_EN to add the if_level / if_hwm occupancy outputs.
module linear_layer_start_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout
`ifdef START_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   if_level,
    output logic [ADDR_WIDTH:0]   if_hwm
`endif
);
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   count, next_count;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  push, pop;

    // Head sits at the oldest occupied slot, so the read address is simply count-1.
    always_comb begin
        push       = if_write & if_write_ce & if_full_n;
        pop        = if_read & if_read_ce & if_empty_n;
        next_count = (push & ~pop) ? count + 1'b1 : (pop & ~push) ? count - 1'b1 : count;
        raddr      = (count == '0) ? '0 : ADDR_WIDTH'(count - 1'b1);
        if_dout    = mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
            mem[0] <= if_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            if_empty_n <= 1'b0;
            if_full_n  <= 1'b1;
        end else begin
            count      <= next_count;
            if_empty_n <= next_count != '0;
            if_full_n  <= next_count != FULL;
        end
    end

`ifdef START_FIFO_LEVEL_EN
    assign if_level = count;

    always_ff @(posedge clk) begin
        if (reset) if_hwm <= '0;
        else if (next_count > if_hwm) if_hwm <= next_count;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count <= FULL);
            assert (!(if_write && if_write_ce && !if_full_n && push));
        end
    end
endmodule

// File: tb/tb_linear_layer_start_fifo.sv
// tb_linear_layer_start_fifo: directed and randomized checks of the start FIFO against a queue model.
module tb_linear_layer_start_fifo;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int DEPTH = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_full_n, if_empty_n;
    logic          if_write_ce = 1'b0, if_write = 1'b0, if_read_ce = 1'b0, if_read = 1'b0;
    logic [DW-1:0] if_din = '0;
    logic [DW-1:0] if_dout;
`ifdef START_FIFO_LEVEL_EN
    logic [AW:0]   if_level, if_hwm;
    int            m_hwm = 0;
`endif

    int            n_tests = 0;
    int            n_fail = 0;
    logic [DW-1:0] q[$];

    always #5 clk = ~clk;

    linear_layer_start_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .if_full_n(if_full_n), .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
        .if_empty_n(if_empty_n), .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout)
`ifdef START_FIFO_LEVEL_EN
        , .if_level(if_level), .if_hwm(if_hwm)
`endif
    );

    // Applies one cycle of requests (called just after a negedge) and advances the queue model.
    task automatic drive(input bit w, input bit wce, input logic [DW-1:0] d, input bit r, input bit rce);
        bit p, o;
        if_write = w; if_write_ce = wce; if_din = d; if_read = r; if_read_ce = rce;
        p = w && wce && q.size() < DEPTH;
        o = r && rce && q.size() > 0;
        @(posedge clk);
        if (o) void'(q.pop_front());
        if (p) q.push_back(d);
`ifdef START_FIFO_LEVEL_EN
        if (q.size() > m_hwm) m_hwm = q.size();
`endif
        @(negedge clk);
        if_write = 0; if_write_ce = 0; if_read = 0; if_read_ce = 0;
    endtask

    task automatic apply_reset(input bit w, input bit r);
        reset = 1; if_write = w; if_write_ce = 1; if_din = 8'hEE; if_read = r; if_read_ce = 1;
        @(posedge clk);
        q.delete();
`ifdef START_FIFO_LEVEL_EN
        m_hwm = 0;
`endif
        @(negedge clk);
        reset = 0; if_write = 0; if_write_ce = 0; if_read = 0; if_read_ce = 0;
    endtask

    task automatic test_reset();
        apply_reset(1, 1);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: empty_n=%b full_n=%b, want 0 1", i, if_empty_n, if_full_n);
            end
            drive(0, 0, 8'h00, 1, 1);
        end
`ifdef START_FIFO_LEVEL_EN
        n_tests++;
        if (if_level !== 0 || if_hwm !== 0) begin
            n_fail++;
            $display("FAIL reset_level: level=%0d hwm=%0d, want 0 0", if_level, if_hwm);
        end
`endif
    endtask

    task automatic test_order();
        logic [DW-1:0] exp [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) drive(1, 1, exp[i], 0, 0);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (if_empty_n !== 1'b1 || if_dout !== exp[i]) begin
                n_fail++;
                $display("FAIL order %0d: empty_n=%b dout=%h, want 1 %h", i, if_empty_n, if_dout, exp[i]);
            end
            drive(0, 0, 8'h00, 1, 1);
        end
        n_tests++;
        if (if_empty_n !== 1'b0) begin
            n_fail++;
            $display("FAIL order_empty: empty_n=%b, want 0", if_empty_n);
        end
    endtask

    task automatic test_full();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, 1, DW'(i), 0, 0);
            n_tests++;
            if (if_full_n !== (i != DEPTH)) begin
                n_fail++;
                $display("FAIL fill %0d: full_n=%b, want %b", i, if_full_n, i != DEPTH);
            end
        end
        drive(1, 1, 8'hFF, 1, 1);
        n_tests++;
        if (if_full_n !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drop: full_n=%b, want 1", if_full_n);
        end
        for (int i = 2; i <= DEPTH; i++) begin
            n_tests++;
            if (if_empty_n !== 1'b1 || if_dout !== DW'(i)) begin
                n_fail++;
                $display("FAIL full_read %0d: empty_n=%b dout=%h, want 1 %h", i, if_empty_n, if_dout, DW'(i));
            end
            drive(0, 0, 8'h00, 1, 1);
        end
        n_tests++;
        if (if_empty_n !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drain: empty_n=%b, want 0 (0xFF leaked)", if_empty_n);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp [13];
        for (int i = 0; i < 3; i++) begin
            exp[i] = DW'(8'hB1 + i);
            drive(1, 1, exp[i], 0, 0);
        end
        for (int i = 0; i < 10; i++) exp[3+i] = DW'(8'hA0 + i);
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (if_dout !== exp[i] || if_empty_n !== 1'b1 || if_full_n !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b %0d: dout=%h e=%b f=%b, want %h 1 1", i, if_dout, if_empty_n, if_full_n, exp[i]);
            end
            drive(1, 1, exp[3+i], 1, 1);
        end
        for (int i = 10; i < 13; i++) begin
            n_tests++;
            if (if_dout !== exp[i] || if_empty_n !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_drain %0d: dout=%h e=%b, want %h 1", i, if_dout, if_empty_n, exp[i]);
            end
            drive(0, 0, 8'h00, 1, 1);
        end
        n_tests++;
        if (if_empty_n !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_empty: empty_n=%b, want 0", if_empty_n);
        end
    endtask

    task automatic test_empty_edges();
        drive(1, 1, 8'h5A, 1, 1);
        n_tests++;
        if (if_empty_n !== 1'b1 || if_dout !== 8'h5A) begin
            n_fail++;
            $display("FAIL no_bypass: empty_n=%b dout=%h, want 1 5a", if_empty_n, if_dout);
        end
        drive(0, 0, 8'h00, 1, 0);
        n_tests++;
        if (if_empty_n !== 1'b1 || if_dout !== 8'h5A) begin
            n_fail++;
            $display("FAIL read_ce_mask: empty_n=%b dout=%h, want 1 5a", if_empty_n, if_dout);
        end
        drive(0, 0, 8'h00, 1, 1);
        drive(1, 0, 8'h77, 0, 0);
        n_tests++;
        if (if_empty_n !== 1'b0) begin
            n_fail++;
            $display("FAIL write_ce_mask: empty_n=%b, want 0", if_empty_n);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) drive(1, 1, DW'(8'hC0 + i), 0, 0);
        apply_reset(1, 1);
        n_tests++;
        if (if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: empty_n=%b full_n=%b, want 0 1", if_empty_n, if_full_n);
        end
`ifdef START_FIFO_LEVEL_EN
        n_tests++;
        if (if_level !== 0 || if_hwm !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_level: level=%0d hwm=%0d, want 0 0", if_level, if_hwm);
        end
        for (int i = 0; i < 5; i++) drive(1, 1, DW'(i), 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 8'h00, 1, 1);
        n_tests++;
        if (if_level !== 0 || if_hwm !== 5) begin
            n_fail++;
            $display("FAIL hwm: level=%0d hwm=%0d, want 0 5", if_level, if_hwm);
        end
`endif
    endtask

    task automatic test_random();
        bit w, r;
        for (int i = 0; i < 400; i++) begin
            // Alternate fill-biased and drain-biased phases so both boundaries get exercised.
            w = (i % 80 < 40) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r = (i % 80 < 40) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive(w, $urandom_range(0, 4) != 0, DW'($urandom), r, $urandom_range(0, 4) != 0);
            n_tests++;
            if (if_empty_n !== (q.size() != 0) || if_full_n !== (q.size() != DEPTH)
                || (q.size() != 0 && if_dout !== q[0])) begin
                n_fail++;
                $display("FAIL random %0d: e=%b f=%b dout=%h, want e=%b f=%b head=%h (size %0d)", i,
                         if_empty_n, if_full_n, if_dout, q.size() != 0, q.size() != DEPTH,
                         q.size() != 0 ? q[0] : 8'h00, q.size());
            end
`ifdef START_FIFO_LEVEL_EN
            n_tests++;
            if (if_level !== (AW+1)'(q.size()) || if_hwm !== (AW+1)'(m_hwm)) begin
                n_fail++;
                $display("FAIL random_level %0d: level=%0d hwm=%0d, want %0d %0d", i, if_level, if_hwm, q.size(), m_hwm);
            end
`endif
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_order();
        test_full();
        test_back_to_back();
        test_empty_edges();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
